vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Divides clk down to a
//             one-cycle pixel strobe and runs the horizontal/vertical counters,
//             sync pulses, visible flag, line/frame/vblank strobes and a
//             wrapping frame counter. Defaults give 800x600@60 from 120 MHz.
//  Ports    :
//    clk          in   system clock
//    nrst         in   asynchronous active-low reset (loads the park state)
//    en           in   run enable; low parks the generator on the next edge
//    pix_en       out  one-clk strobe on the first cycle of each pixel
//    hcount       out  current column, 0..H_TOTAL-1
//    vcount       out  current line, 0..V_TOTAL-1
//    hsync        out  horizontal sync, active level H_SYNC_POL
//    vsync        out  vertical sync, active level V_SYNC_POL
//    visible      out  pixel lies inside the visible area
//    line_start   out  strobe when hcount becomes 0
//    frame_start  out  strobe when (hcount,vcount) becomes (0,0)
//    vblank_start out  strobe when (hcount,vcount) becomes (0,V_VISIBLE)
//    frame_count  out  frames started since reset, wraps mod 2^FCW
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV    = 3,
    parameter int CW         = 11,
    parameter int FCW        = 8,
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           en,
    output logic           pix_en,
    output logic [CW-1:0]  hcount,
    output logic [CW-1:0]  vcount,
    output logic           hsync,
    output logic           vsync,
    output logic           visible,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // A one-cycle divider still needs a 1-bit tick register to stay legal.
    localparam int TW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TW-1:0] C_TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_VIS     = CW'(H_VISIBLE);
    localparam logic [CW-1:0] C_V_VIS     = CW'(V_VISIBLE);
    localparam logic [CW-1:0] C_HS_FIRST  = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] C_HS_LAST   = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] C_VS_FIRST  = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] C_VS_LAST   = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [TW-1:0] r_tick;

    logic          w_adv;
    logic          w_hwrap;
    logic [TW-1:0] w_tick_nxt;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_line_start;
    logic          w_frame_start;
    logic          w_vblank_start;
    logic          w_hsync_act;
    logic          w_vsync_act;
    logic          w_visible;

    // Next-state computation. Parking (en low) forces the counters to their
    // last values with the tick at its wrap point, so the first enabled edge
    // afterwards advances straight into (0,0) and starts a fresh frame.
    always_comb begin
        w_adv      = en && (r_tick == C_TICK_LAST);
        w_hwrap    = w_adv && (hcount == C_H_LAST);
        w_tick_nxt = C_TICK_LAST;
        w_h_nxt    = C_H_LAST;
        w_v_nxt    = C_V_LAST;

        if (en) begin
            w_tick_nxt = (r_tick == C_TICK_LAST) ? '0 : r_tick + TW'(1);

            w_h_nxt = hcount;
            if (w_adv) begin
                w_h_nxt = (hcount == C_H_LAST) ? '0 : hcount + CW'(1);
            end

            w_v_nxt = vcount;
            if (w_hwrap) begin
                w_v_nxt = (vcount == C_V_LAST) ? '0 : vcount + CW'(1);
            end
        end
    end

    // Decodes are taken from the next counter values so every registered
    // output lines up with the hcount/vcount it describes.
    always_comb begin
        w_line_start   = w_adv && (w_h_nxt == '0);
        w_frame_start  = w_line_start && (w_v_nxt == '0);
        w_vblank_start = w_line_start && (w_v_nxt == C_V_VIS);
        w_hsync_act    = en && (w_h_nxt >= C_HS_FIRST) && (w_h_nxt <= C_HS_LAST);
        w_vsync_act    = en && (w_v_nxt >= C_VS_FIRST) && (w_v_nxt <= C_VS_LAST);
        w_visible      = en && (w_h_nxt < C_H_VIS) && (w_v_nxt < C_V_VIS);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tick       <= C_TICK_LAST;
            hcount       <= C_H_LAST;
            vcount       <= C_V_LAST;
            pix_en       <= 1'b0;
            hsync        <= !H_SYNC_POL;
            vsync        <= !V_SYNC_POL;
            visible      <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            r_tick       <= w_tick_nxt;
            hcount       <= w_h_nxt;
            vcount       <= w_v_nxt;
            pix_en       <= w_adv;
            hsync        <= w_hsync_act ? H_SYNC_POL : !H_SYNC_POL;
            vsync        <= w_vsync_act ? V_SYNC_POL : !V_SYNC_POL;
            visible      <= w_visible;
            line_start   <= w_line_start;
            frame_start  <= w_frame_start;
            vblank_start <= w_vblank_start;
            if (w_frame_start) begin
                frame_count <= frame_count + FCW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Scoreboard bench for vga_timing_gen. Two instances run side by
//             side: index 0 uses the 800x600 defaults, index 1 a tiny raster
//             (CLK_DIV=1, H=4/1/2/1, V=3/1/1/1, polarities 0). Expected outputs
//             come from an arithmetic model of the raster (pixel number =
//             cycles since start / CLK_DIV, then div/mod by line and frame
//             size) and are queued per edge; a monitor compares 1 time unit
//             after each edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int CD [2] = '{3, 1};
    localparam int HV [2] = '{800, 4};
    localparam int HF [2] = '{40, 1};
    localparam int HS [2] = '{128, 2};
    localparam int HB [2] = '{88, 1};
    localparam int VV [2] = '{600, 3};
    localparam int VF [2] = '{1, 1};
    localparam int VS [2] = '{4, 1};
    localparam int VB [2] = '{23, 1};
    localparam bit HP [2] = '{1'b1, 1'b0};
    localparam bit VP [2] = '{1'b1, 1'b0};

    logic       clk = 1'b0;
    logic [1:0] nrst = 2'b11;
    logic [1:0] en   = 2'b00;
    logic       done_a = 1'b0;
    logic       done_b = 1'b0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    logic        a_pix_en, a_hsync, a_vsync, a_visible, a_ls, a_fs, a_vbs;
    logic [10:0] a_hcount, a_vcount;
    logic [7:0]  a_fc;
    logic        b_pix_en, b_hsync, b_vsync, b_visible, b_ls, b_fs, b_vbs;
    logic [10:0] b_hcount, b_vcount;
    logic [7:0]  b_fc;

    vga_timing_gen u_dut_a (
        .clk(clk), .nrst(nrst[0]), .en(en[0]),
        .pix_en(a_pix_en), .hcount(a_hcount), .vcount(a_vcount),
        .hsync(a_hsync), .vsync(a_vsync), .visible(a_visible),
        .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vbs),
        .frame_count(a_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(CD[1]), .CW(11), .FCW(8),
        .H_VISIBLE(HV[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
        .V_VISIBLE(VV[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
        .H_SYNC_POL(HP[1]), .V_SYNC_POL(VP[1])
    ) u_dut_b (
        .clk(clk), .nrst(nrst[1]), .en(en[1]),
        .pix_en(b_pix_en), .hcount(b_hcount), .vcount(b_vcount),
        .hsync(b_hsync), .vsync(b_vsync), .visible(b_visible),
        .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vbs),
        .frame_count(b_fc)
    );

    // Output vector: {pix_en,hsync,vsync,visible,line,frame,vblank,fc[7:0],h[10:0],v[10:0]}
    logic [36:0] got_a, got_b;
    assign got_a = {a_pix_en, a_hsync, a_vsync, a_visible, a_ls, a_fs, a_vbs, a_fc, a_hcount, a_vcount};
    assign got_b = {b_pix_en, b_hsync, b_vsync, b_visible, b_ls, b_fs, b_vbs, b_fc, b_hcount, b_vcount};

    function automatic int htot(input int g);
        return HV[g] + HF[g] + HS[g] + HB[g];
    endfunction

    function automatic int vtot(input int g);
        return VV[g] + VF[g] + VS[g] + VB[g];
    endfunction

    // Frame counter value n cycles into a run that began with counter fcb.
    function automatic int fc_at(input int g, input int n, input int fcb);
        return (fcb + (n / CD[g]) / (htot(g) * vtot(g)) + 1) % 256;
    endfunction

    // Expected outputs n cycles after a run started (n=0 is the (0,0) cycle).
    function automatic logic [36:0] ref_out(input int g, input int n, input int fcb);
        int p, h, line, v;
        bit first, hs_act, vs_act, vis;
        p      = n / CD[g];
        first  = (n % CD[g]) == 0;
        h      = p % htot(g);
        line   = p / htot(g);
        v      = line % vtot(g);
        hs_act = (h >= HV[g] + HF[g]) && (h < HV[g] + HF[g] + HS[g]);
        vs_act = (v >= VV[g] + VF[g]) && (v < VV[g] + VF[g] + VS[g]);
        vis    = (h < HV[g]) && (v < VV[g]);
        return {first, hs_act ? HP[g] : !HP[g], vs_act ? VP[g] : !VP[g], vis,
                first && h == 0, first && h == 0 && v == 0, first && h == 0 && v == VV[g],
                8'(fc_at(g, n, fcb)), 11'(h), 11'(v)};
    endfunction

    function automatic logic [36:0] park_out(input int g, input int fc);
        return {1'b0, !HP[g], !VP[g], 1'b0, 3'b000, 8'(fc), 11'(htot(g) - 1), 11'(vtot(g) - 1)};
    endfunction

    task automatic check(input string name, input logic [36:0] got, input logic [36:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_sb
        logic [36:0] q [$];
        int  n;
        int  fc_base;
        int  fc_held;
        bit  run;

        // Reference model: advances once per edge from the inputs as seen at
        // that edge and queues the outputs the DUT must show afterwards.
        initial begin
            n = 0; fc_base = 0; fc_held = 0; run = 0;
            forever begin
                @(posedge clk);
                if (!nrst[g]) begin
                    run     = 0;
                    fc_held = 0;
                end else if (!en[g]) begin
                    if (run) fc_held = fc_at(g, n, fc_base);
                    run = 0;
                end else if (!run) begin
                    run     = 1;
                    n       = 0;
                    fc_base = fc_held;
                end else begin
                    n++;
                end
                q.push_back(run ? ref_out(g, n, fc_base) : park_out(g, fc_held));
            end
        end

        // Monitor: compares the DUT against the queued expectation.
        initial begin
            logic [36:0] exp;
            forever begin
                @(posedge clk);
                #1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb%0d_empty t=%0t got=%h expected=queued_value", g, $time,
                             (g == 0) ? got_a : got_b);
                end else begin
                    exp = q.pop_front();
                    check((g == 0) ? "out_a" : "out_b", (g == 0) ? got_a : got_b, exp);
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called on a negedge; reset edges land strictly between clock edges.
    task automatic async_reset(input int g);
        #($urandom_range(1, 3));
        nrst[g] = 1'b0;
        en[g]   = 1'($urandom_range(0, 1));
        #1;
        check((g == 0) ? "async_park_a" : "async_park_b", (g == 0) ? got_a : got_b, park_out(g, 0));
        cyc(2);
        en[g] = 1'b1;
        #($urandom_range(1, 3));
        nrst[g] = 1'b1;
    endtask

    task automatic en_drop(input int g, input int k);
        en[g] = 1'b0;
        cyc(k);
        en[g] = 1'b1;
    endtask

    // Default-timing instance.
    initial begin
        bit found;
        en[0] = 1'b1;
        #1 nrst[0] = 1'b0;
        cyc(5);
        #3 nrst[0] = 1'b1;
        cyc(2 * 1056 * 3);
        found = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (a_hcount == 11'd123) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_hcount123 got=timeout expected=hcount_123");
        end else begin
            en_drop(0, $urandom_range(1, 20));
        end
        repeat (8) begin
            cyc($urandom_range(50, 3000));
            if ($urandom_range(0, 1) == 0) en_drop(0, $urandom_range(1, 10));
            else async_reset(0);
        end
        cyc(100);
        done_a = 1'b1;
    end

    // Small-raster instance: long uninterrupted run to wrap frame_count.
    initial begin
        en[1] = 1'b1;
        #1 nrst[1] = 1'b0;
        cyc(4);
        #2 nrst[1] = 1'b1;
        cyc(300 * 48);
        repeat (10) begin
            cyc($urandom_range(20, 300));
            if ($urandom_range(0, 1) == 0) en_drop(1, $urandom_range(1, 10));
            else async_reset(1);
        end
        cyc(100);
        done_b = 1'b1;
    end

    initial begin
        wait (done_a && done_b);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog t=%0t got=not_finished expected=finished", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
